mc_controller: RTL
==================

// Module: mc_controller
// PURPOSE
//  Multicycle RV32I control unit; next generation of the single-cycle controller.
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB through a Moore FSM that drives a shared-memory,
//  shared-ALU datapath. Adds a memory wait-state handshake, full branch funct3 decode,
//  JALR/LUI/AUIPC and illegal-opcode trapping. Sits between instruction register and datapath.
// PARAMETERS
//  HAS_MEM_WAIT     1  1: honour mem_ready; 0: memory is single-cycle, mem_ready ignored (treated 1)
//  TRAP_ON_ILLEGAL  1  1: illegal opcode halts in TRAP until reset; 0: illegal treated as NOP
//  ALUCTRL_W        4  width of alu_control
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  opcode       in   7  instr[6:0] from instruction register
//  funct3       in   3  instr[14:12]
//  funct7_5     in   1  instr[30]
//  zero         in   1  ALU result == 0
//  lt           in   1  signed A < B (from ALU compare)
//  ltu          in   1  unsigned A < B
//  mem_ready    in   1  memory completes the current request this cycle
//  mem_req      out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
//  mem_write    out  1  request is a write
//  adr_src      out  1  0: address = PC, 1: address = ALUOut
//  ir_write     out  1  latch instruction and OldPC
//  pc_write     out  1  PC update enable
//  reg_write    out  1  register file write enable
//  alu_src_a    out  2  00 PC, 01 OldPC, 10 rs1, 11 zero
//  alu_src_b    out  2  00 rs2, 01 imm, 10 const 4
//  imm_src      out  3  I, S, B, J, U encodings (package constants)
//  result_src   out  2  00 ALUOut, 01 mem data, 10 ALU result
//  alu_control  out  ALUCTRL_W  ALU operation (package constants)
//  illegal      out  1  unsupported opcode or branch funct3 decoded
// BEHAVIOUR
//  Reset: state <= FETCH. While rst_n = 0 every enable (mem_req, mem_write, ir_write, pc_write,
//  reg_write) and illegal = 0; selects = 0. Reset mid-instruction aborts it; no partial write.
//  States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL,
//  JALR, LUI, AUIPC, TRAP.
//  FETCH: mem_req=1, adr_src=0. ALU = PC+4. ir_write and pc_write pulse only in the mem_ready cycle;
//   then -> DECODE. Otherwise hold FETCH with all outputs stable.
//  DECODE: ALU = OldPC+imm(B) for branch target. Next state by opcode:
//   load/store->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, JAL->JAL, JALR->JALR,
//   LUI->LUI, AUIPC->AUIPC, other->TRAP (illegal).
//  MEMADR: rs1+imm -> MEMREAD (load) or MEMWRITE (store).
//  MEMREAD/MEMWRITE: mem_req=1, adr_src=1; wait on mem_ready like FETCH.
//   MEMREAD -> MEMWB; MEMWRITE -> FETCH.
//  MEMWB: reg_write=1, result_src=01 -> FETCH.
//  EXECR/EXECI -> ALUWB. ALUWB: reg_write=1, result_src=00 -> FETCH.
//  JAL: pc_write=1 (target from ALUOut), ALU = OldPC+4 -> ALUWB.
//  JALR: ALU = rs1+imm, pc_write=1 with result_src=10, LSB forced 0 by datapath; -> JALR link.
//   Link write uses ALUWB after OldPC+4, so JALR takes one extra cycle.
//  LUI: ALU = 0+imm(U). AUIPC: ALU = OldPC+imm(U). Both -> ALUWB.
//  BRANCH: ALU = rs1-rs2; taken cond by funct3:
//   000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
//   Taken -> pc_write=1, result_src=00. funct3 010/011 -> illegal, no PC update. -> FETCH.
//  ALU decode: add for ALUOp add; sub for branch; funct for EXECR/EXECI.
//   sub only when R-type & funct7_5. sra/srl by funct7_5 for both R and I shifts.
//  TRAP: TRAP_ON_ILLEGAL=1: illegal=1 sticky, FSM stays in TRAP, no enables until reset.
//   TRAP_ON_ILLEGAL=0: illegal pulses 1 cycle in DECODE, FSM -> FETCH (NOP).
//  Latency with zero waits: branch 3; R/I/LUI/AUIPC/store/JAL 4; load/JALR 5.
//   Each wait cycle adds 1.
// STRUCTURE
//  Package rv_ctrl_pkg holds the state enum, opcode constants, ALU op constants,
//  imm_src / result_src / src-sel encodings and the ALUOp enum.
//  One sub-module, mc_alu_decoder: combinational ALUOp+funct3+op5+funct7_5 -> alu_control.
//  FSM, output decode and branch-condition logic stay in mc_controller.
// TESTING
//  add x3,x1,x2 with mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB;
//   reg_write=1 in cycle 4 only, alu_control=ADD.
//  lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD -> mem_req held;
//   ir_write/pc_write single pulse; total 10 cycles.
//  bltu with ltu=1 -> pc_write=1 in BRANCH. bge with lt=1 -> pc_write=0.
//   funct3=010 -> illegal.
//  Opcode 0x7F with TRAP_ON_ILLEGAL=1 -> illegal stays 1, no enables for 20 cycles;
//   rst_n low then high -> FETCH, illegal=0.
//  srai (funct7_5=1, funct3=101) -> SRA; addi with instr[30]=1 -> ADD, not SUB.
//  rst_n asserted in MEMWRITE while mem_ready=0 -> all enables 0 same cycle;
//   first post-reset state FETCH.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes,
// ALU operations and the datapath select fields.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLINK,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUOp request and the
// instruction's funct fields.
module mc_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [3:0] alu_control
);

    // instr[30] selects SUB only for R-type; for addi it is immediate bits.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing a shared-memory,
// shared-ALU datapath, with memory wait states and illegal-opcode trapping.
module mc_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit HAS_MEM_WAIT    = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int ALUCTRL_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [1:0]           result_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal
);

    state_t     state;
    state_t     state_next;
    alu_op_t    alu_op;
    logic [3:0] dec_alu;
    logic       ready;
    logic       branch_taken;
    logic       branch_bad;

    assign ready = HAS_MEM_WAIT ? mem_ready : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        branch_bad   = 1'b0;
        case (funct3)
            3'b000:  branch_taken = zero;
            3'b001:  branch_taken = !zero;
            3'b100:  branch_taken = lt;
            3'b101:  branch_taken = !lt;
            3'b110:  branch_taken = ltu;
            3'b111:  branch_taken = !ltu;
            default: branch_bad   = 1'b1;
        endcase
    end

    // Everything is forced low while reset is held so an aborted access
    // can never leave a write enable asserted.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        imm_src    = IMM_I;
        result_src = RES_ALUOUT;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    if (ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Speculative target into ALUOut; JAL needs the J immediate.
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = S_MEMADR;
                        OP_R:              state_next = S_EXECR;
                        OP_I:              state_next = S_EXECI;
                        OP_BRANCH:         state_next = S_BRANCH;
                        OP_JAL:            state_next = S_JAL;
                        OP_JALR:           state_next = S_JALR;
                        OP_LUI:            state_next = S_LUI;
                        OP_AUIPC:          state_next = S_AUIPC;
                        default: begin
                            illegal    = 1'b1;
                            state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = (opcode == OP_STORE) ? IMM_S : IMM_I;
                    state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (ready) begin
                        state_next = S_MEMWB;
                    end
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (ready) begin
                        state_next = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEMDATA;
                    state_next = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_FUNCT;
                    state_next = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_I;
                    alu_op     = ALUOP_FUNCT;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_RS2;
                    alu_op     = ALUOP_SUB;
                    result_src = RES_ALUOUT;
                    pc_write   = branch_taken;
                    illegal    = branch_bad;
                    state_next = S_FETCH;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    result_src = RES_ALUOUT;
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    state_next = S_ALUWB;
                end
                S_JALR: begin
                    // Target goes straight from the ALU; the link value needs
                    // its own ALU pass afterwards.
                    alu_src_a  = SRCA_RS1;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_I;
                    pc_write   = 1'b1;
                    result_src = RES_ALURESULT;
                    state_next = S_JALRLINK;
                end
                S_JALRLINK: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_FOUR;
                    state_next = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a  = SRCA_ZERO;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_U;
                    state_next = S_ALUWB;
                end
                S_AUIPC: begin
                    alu_src_a  = SRCA_OLDPC;
                    alu_src_b  = SRCB_IMM;
                    imm_src    = IMM_U;
                    state_next = S_ALUWB;
                end
                S_TRAP: begin
                    illegal    = TRAP_ON_ILLEGAL;
                    state_next = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                end
                default: state_next = S_FETCH;
            endcase
        end
    end

    mc_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (opcode[5]),
        .funct7_5    (funct7_5),
        .alu_control (dec_alu)
    );

    assign alu_control = ALUCTRL_W'(dec_alu);

endmodule
